// File: rtl/div_result_display.sv
// div_result_display: latches a 4-bit divider result and shows it on a
// time-multiplexed 4-digit common-anode 7-segment display.
// Quotient goes on the left pair of digits, remainder on the right pair.
// Divide-by-zero shows "Err".
module div_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] q,
    input  logic [3:0] r,
    input  logic       e,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       shown
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic [3:0]    q_reg;
    logic [3:0]    r_reg;
    logic          e_reg;
    logic          shown_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;

    logic          wrap;
    logic [3:0]    value;
    logic          tens;
    logic [3:0]    units;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    // Decimal digit (0..9) to segment pattern; out-of-range blanks
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 7'b1000000;
            4'd1:    seg_lut = 7'b1111001;
            4'd2:    seg_lut = 7'b0100100;
            4'd3:    seg_lut = 7'b0110000;
            4'd4:    seg_lut = 7'b0011001;
            4'd5:    seg_lut = 7'b0010010;
            4'd6:    seg_lut = 7'b0000010;
            4'd7:    seg_lut = 7'b1111000;
            4'd8:    seg_lut = 7'b0000000;
            4'd9:    seg_lut = 7'b0010000;
            default: seg_lut = SEG_BLANK;
        endcase
    endfunction

    assign wrap = (cnt_reg == CW'(REFRESH_DIV - 1));

    // Refresh counter and digit index: idx steps once per REFRESH_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else if (wrap) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Capture registers: latest load wins, no queueing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg     <= 4'd0;
            r_reg     <= 4'd0;
            e_reg     <= 1'b0;
            shown_reg <= 1'b0;
        end else if (load) begin
            q_reg     <= q;
            r_reg     <= r;
            e_reg     <= e;
            shown_reg <= 1'b1;
        end
    end

    // Digit decode for the currently selected position (compare/subtract BCD)
    always_comb begin
        value    = idx_reg[1] ? q_reg : r_reg;
        tens     = (value >= 4'd10);
        units    = tens ? (value - 4'd10) : value;
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;

        case (idx_reg)
            2'd0:    an_next = 4'b1110;
            2'd1:    an_next = 4'b1101;
            2'd2:    an_next = 4'b1011;
            default: an_next = 4'b0111;
        endcase

        // Odd positions carry tens (blanked when zero), even carry units
        if (idx_reg[0])
            seg_next = tens ? SEG_ONE : SEG_BLANK;
        else
            seg_next = seg_lut(units);

        if (!shown_reg) begin
            seg_next = SEG_BLANK;
        end else if (e_reg) begin
            case (idx_reg)
                2'd3:    seg_next = SEG_E;
                2'd2:    seg_next = SEG_R;
                2'd1:    seg_next = SEG_R;
                default: seg_next = SEG_BLANK;
            endcase
        end
    end

    // Registered pin drivers, one cycle behind the state they decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an    = an_reg;
    assign seg   = seg_reg;
    assign shown = shown_reg;

endmodule

// File: tb/tb_div_result_display.sv
// Testbench for div_result_display: directed test-plan steps followed by
// randomized loads/resets, checked by a scoreboard against a cycle-count
// reference model of the display.
module tb_div_result_display;

    localparam int RD = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       shown;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] q_in;
    logic [3:0] r_in;
    logic       e_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       shown;

    int tests  = 0;
    int failed = 0;
    obs_t exp_q[$];

    // Reference model state
    int         m_n;      // non-reset edges since last reset
    logic [3:0] m_q, m_r;
    logic       m_e, m_shown;

    logic [6:0] digit_tbl [0:9];

    div_result_display #(.REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .q     (q_in),
        .r     (r_in),
        .e     (e_in),
        .an    (an),
        .seg   (seg),
        .shown (shown)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_an(input int pos);
        logic [3:0] a;
        a = 4'b1111;
        a[pos] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] model_seg(input int pos);
        int v;
        if (!m_shown) return 7'b1111111;
        if (m_e) begin
            case (pos)
                3:       return 7'b0000110;
                2, 1:    return 7'b0101111;
                default: return 7'b1111111;
            endcase
        end
        v = (pos >= 2) ? int'(m_q) : int'(m_r);
        if (pos % 2 == 1) begin
            if (v / 10 == 0) return 7'b1111111;
            return digit_tbl[v / 10];
        end
        return digit_tbl[v % 10];
    endfunction

    // Drive one cycle of inputs, predict the outputs after the coming edge
    task automatic step(input logic rst, input logic ld, input logic [3:0] qv,
                        input logic [3:0] rv, input logic ev);
        obs_t o;
        int pos;
        @(negedge clk);
        rst_n = rst; load = ld; q_in = qv; r_in = rv; e_in = ev;
        if (!rst) begin
            o.an = 4'b1111; o.seg = 7'b1111111; o.shown = 1'b0;
            m_n = 0; m_q = 0; m_r = 0; m_e = 0; m_shown = 0;
        end else begin
            pos   = (m_n / RD) % 4;
            o.an  = model_an(pos);
            o.seg = model_seg(pos);
            if (ld) begin
                m_q = qv; m_r = rv; m_e = ev; m_shown = 1'b1;
                $display("[TB] load q=%0d r=%0d e=%0d at frame cycle %0d",
                         qv, rv, ev, m_n % (4 * RD));
            end
            m_n++;
            o.shown = m_shown;
        end
        exp_q.push_back(o);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    // Monitor: pop the prediction for each edge and compare
    always @(posedge clk) begin
        obs_t o;
        #1;
        if (exp_q.size() != 0) begin
            o = exp_q.pop_front();
            tests++;
            if (an !== o.an || seg !== o.seg || shown !== o.shown) begin
                failed++;
                $display("FAIL display: got an=%b seg=%b shown=%b, expected an=%b seg=%b shown=%b",
                         an, seg, shown, o.an, o.seg, o.shown);
            end
        end
    end

    initial begin
        digit_tbl[0] = 7'b1000000; digit_tbl[1] = 7'b1111001;
        digit_tbl[2] = 7'b0100100; digit_tbl[3] = 7'b0110000;
        digit_tbl[4] = 7'b0011001; digit_tbl[5] = 7'b0010010;
        digit_tbl[6] = 7'b0000010; digit_tbl[7] = 7'b1111000;
        digit_tbl[8] = 7'b0000000; digit_tbl[9] = 7'b0010000;
        rst_n = 1'b0; load = 1'b0; q_in = 0; r_in = 0; e_in = 0;
        m_n = 0; m_q = 0; m_r = 0; m_e = 0; m_shown = 0;

        // Reset held with load asserted
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd9, 4'd0, 1'b0);
        idle(6);

        // Two-digit quotient
        step(1'b1, 1'b1, 4'd13, 4'd2, 1'b0);
        idle(4 * RD + 2);

        // Zero result
        step(1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        idle(4 * RD + 2);

        // Error, then recovery
        step(1'b1, 1'b1, 4'd15, 4'd15, 1'b1);
        idle(4 * RD + 2);
        step(1'b1, 1'b1, 4'd10, 4'd10, 1'b0);
        idle(4 * RD + 2);

        // Collision: load on the edge where the scan moves from idx0 to idx1
        for (int i = 0; i < 4 * RD && (m_n % (4 * RD)) != RD - 1; i++) idle(1);
        step(1'b1, 1'b1, 4'd0, 4'd15, 1'b0);
        idle(4 * RD);

        // Reset mid-frame while idx=2
        for (int i = 0; i < 4 * RD && ((m_n / RD) % 4) != 2; i++) idle(1);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(4 * RD + 2);

        // Randomized loads with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom));
            else if ($urandom_range(0, 7) == 0)
                step(1'b1, 1'b1, 4'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0));
            else
                step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/div_result_display.md
# div_result_display

Downstream consumer of the 4-bit combinational divider. Captures the quotient, remainder and divide-by-zero flag on a load strobe and drives a 4-digit common-anode 7-segment display through time-multiplexing. The quotient appears in decimal on the left pair of digits and the remainder on the right pair. On a divide-by-zero error the block shows "Err".

## Interface
- REFRESH_DIV, default 50000: clock cycles spent on each digit before the scan advances. Legal range is 2 or more.
- clk  in  1: system clock; all state changes on the rising edge.
- rst_n  in  1: reset, synchronous and active-low.
- load  in  1: capture strobe. When sampled high, the block latches q, r and e.
- q  in  4: quotient from the divider, 0..15.
- r  in  4: remainder from the divider, 0..15.
- e  in  1: divide-by-zero flag from the divider.
- an  out  4: digit enables, active-low. an[3] is the leftmost digit and an[0] the rightmost.
- seg  out  7: segments {g,f,e,d,c,b,a}, active-low.
- shown  out  1: high once at least one load has been captured since reset.

## Operation
- **Capture registers**: q_l, r_l, e_l and shown. On any edge with load=1, they take q, r, e and 1 respectively. Otherwise they hold.
- **Refresh counter**: cnt counts 0..REFRESH_DIV-1, then wraps to 0.
- **Digit index**: idx is 2 bits. It advances 0→1→2→3→0 on the edge where cnt wraps and holds otherwise.
- **Digit mapping**:
  - idx 0 → an=1110, remainder units.
  - idx 1 → an=1101, remainder tens.
  - idx 2 → an=1011, quotient units.
  - idx 3 → an=0111, quotient tens.
- **Binary to decimal**: tens = (v ≥ 10) ? 1 : 0; units = v − 10·tens. This is done with a compare and a subtract; no divider is used.
- **Leading-zero blanking**: a tens digit equal to 0 shows blank. A units digit always shows, including 0.
- **Error mode** (e_l=1): ignore q_l and r_l.
  - idx 3 = 'E' (0000110)
  - idx 2 = 'r' (0101111)
  - idx 1 = 'r' (0101111)
  - idx 0 = blank
- **Before the first load** (shown=0): seg is blank (1111111) for every idx. an still scans.
- **Segment codes**:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- **Load and scan on the same edge**: both take effect. The new data is decoded against the new idx.
- **Reload while displaying**: the new value replaces the old one. There is no queueing; the latest load wins.

## Timing
- **Reset**, on any edge with rst_n=0, regardless of load:
  - cnt=0, idx=0, q_l=0, r_l=0, e_l=0, shown=0
  - an=1111, seg=1111111
- **Output registers**: an and seg are registered. Each is decoded from the post-edge idx and latch values and appears one cycle later. The total latency is 1 cycle from an idx change or a load edge to the pins.
- **First edge after reset release**: an=1110, seg=blank.
- **Load visibility**: after load is sampled at edge N, seg shows the new value at edge N+1, but only if the selected digit is affected. Every digit shows the new value within 4·REFRESH_DIV+1 cycles.
- **Digit dwell**: each digit is enabled for exactly REFRESH_DIV cycles. The full frame is 4·REFRESH_DIV cycles.
- **an encoding**: exactly one an bit is low at any time after the first post-reset edge. an is never 1111 except during reset and the single edge of reset.
- **Mid-frame reset**: aborts the scan immediately. There is no partial frame after release; the scan restarts at idx 0.
- **load held high**: recaptures every cycle. This is legal.

## Test plan
1. **Reset**: hold rst_n=0 for 3 cycles with load=1, q=9. Required: an=1111, seg=1111111, shown=0 throughout. After release, an=1110 and seg=blank, with shown=0.
2. **Two-digit quotient**: REFRESH_DIV=4; load with q=13, r=2, e=0. Required, scanning over a frame:
   - idx0: seg=0100100 ('2')
   - idx1: blank
   - idx2: 0110000 ('3')
   - idx3: 1111001 ('1')
   - each digit for exactly 4 cycles
3. **Zero result**: load q=0, r=0. Required: idx0 and idx2 show 1000000; idx1 and idx3 are blank.
4. **Error**: load e=1 with q=15, r=15. Required: 'E', 'r', 'r', blank on an=0111, 1011, 1101, 1110. Then load e=0, q=10, r=10; 'E' is replaced by '1' within one frame.
5. **Collision**: assert load on the same edge that cnt wraps from 3 to 0 (idx 0→1), with r=15. Required: the next cycle shows an=1101, seg=1111001.
6. **Reset mid-frame**: assert rst_n=0 for 1 cycle while idx=2. Required: all latches clear; after release the scan resumes at an=1110 with shown=0 and blank segments.
